// File: rtl/core_run_ctrl.sv
// Run-control responder: gates the core clock, fires the first fetch,
// counts cycles/decodes and stops on halt or watchdog expiry.
module core_run_ctrl #(
    parameter int          CYCLE_CNT_W     = 32,
    parameter int          WATCHDOG_CYCLES = 5000,
    parameter logic [31:0] HALT_INSTR      = 32'h0000006F,
    parameter int          START_DELAY     = 2,
    parameter int          DRAIN_CYCLES    = 10
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   go,
    input  logic                   clear,
    input  logic                   decode_valid,
    input  logic [31:0]            decode_instr,
    output logic                   core_clk_en,
    output logic                   fetch_start,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [CYCLE_CNT_W-1:0] cycle_count,
    output logic [CYCLE_CNT_W-1:0] instr_count
);

    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    localparam int SD_W = $clog2(START_DELAY + 1);
    localparam int DR_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
    localparam logic [SD_W-1:0] SD_LAST = SD_W'(START_DELAY - 1);
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WARMUP,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    logic [WD_W-1:0] wd_cnt;
    logic [SD_W-1:0] warm_cnt;
    logic [DR_W-1:0] drain_cnt;
    logic            halt;

    assign halt = decode_valid && (decode_instr == HALT_INSTR);

    function automatic logic [CYCLE_CNT_W-1:0] sat_inc(
        input logic [CYCLE_CNT_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // The watchdog saturates too, so a halt that wins against expiry
    // cannot trigger a second expiry later in DRAIN.
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            state       <= IDLE;
            core_clk_en <= 1'b0;
            fetch_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
            wd_cnt      <= '0;
            warm_cnt    <= '0;
            drain_cnt   <= '0;
        end else begin
            fetch_start <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (go) begin
                        state       <= WARMUP;
                        core_clk_en <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                        instr_count <= '0;
                        warm_cnt    <= '0;
                    end
                end
                WARMUP: begin
                    if (warm_cnt == SD_LAST) begin
                        state       <= RUN;
                        fetch_start <= 1'b1;
                        wd_cnt      <= '0;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end
                RUN: begin
                    cycle_count <= sat_inc(cycle_count);
                    if (decode_valid) begin
                        instr_count <= sat_inc(instr_count);
                    end
                    if (wd_cnt != '1) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                    if (halt) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else if (wd_cnt == WD_LAST) begin
                        state       <= DONE;
                        core_clk_en <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        timeout     <= 1'b1;
                    end
                end
                DRAIN: begin
                    cycle_count <= sat_inc(cycle_count);
                    drain_cnt   <= drain_cnt + 1'b1;
                    if (wd_cnt != '1) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                    if (wd_cnt == WD_LAST) begin
                        state       <= DONE;
                        core_clk_en <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        timeout     <= 1'b1;
                    end else if (drain_cnt == DR_LAST) begin
                        state       <= DONE;
                        core_clk_en <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        timeout     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
